fpu_iter_adapter: RTL

FPU_ITER_ADAPTER -- requirements
Module: fpu_iter_adapter

---
 rtl/fpu_iter_adapter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_iter_adapter.sv
// rtl/fpu_iter_adapter.sv - handshake adapter around an iterative FPU core with a result FIFO
// Optional build macro: FPU_ITER_TIMEOUT_EN (WAIT-state watchdog, sticky timeout_o)
module fpu_iter_adapter #(
  parameter int WIDTH          = 64,
  parameter int OP_W           = 5,
  parameter int TAG_W          = 8,
  parameter int OUT_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [3*WIDTH-1:0]   operands_i,
  input  logic [OP_W-1:0]      op_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 flush_i,
  output logic                 core_start_o,
  output logic [WIDTH-1:0]     core_opa_o,
  output logic [WIDTH-1:0]     core_opb_o,
  output logic [WIDTH-1:0]     core_opc_o,
  output logic [OP_W-1:0]      core_op_o,
  input  logic                 core_done_i,
  input  logic [WIDTH-1:0]     core_result_i,
  input  logic [4:0]           core_status_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     result_o,
  output logic [4:0]           status_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int ENT_W = WIDTH + 5 + TAG_W;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    opa_q, opa_d, opb_q, opb_d, opc_q, opc_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                start_q, start_d;

  logic [ENT_W-1:0]    mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                accept;
  logic                push;
  logic                pop;
  logic [ENT_W-1:0]    push_data;
  logic                tmo_fire;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready_o   = (state_q == S_IDLE) && (count_q < CNT_W'(OUT_DEPTH)) && !flush_i;
  assign accept       = in_valid_i && in_ready_o;
  assign core_start_o = start_q;
  assign core_opa_o   = opa_q;
  assign core_opb_o   = opb_q;
  assign core_opc_o   = opc_q;
  assign core_op_o    = op_q;
  assign out_valid_o  = (count_q != '0);
  assign pop          = out_valid_o && out_ready_i;
  assign busy_o       = (state_q != S_IDLE) || (count_q != '0);
  assign {result_o, status_o, tag_o} = mem_q[rptr_q];

`ifdef FPU_ITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  // Count WAIT cycles without a completion; fire on the TIMEOUT_CYCLES-th one
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    tmo_fire  = 1'b0;
    if (state_q == S_START) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_WAIT && !core_done_i) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_fire  = 1'b1;
        timeout_d = 1'b1;
      end
    end
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state logic: accept, start pulse, completion capture and flush handling
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    op_d      = op_q;
    tag_d     = tag_q;
    start_d   = 1'b0;
    push      = 1'b0;
    push_data = {core_result_i, core_status_i, tag_q};
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d   = operands_i[0*WIDTH +: WIDTH];
          opb_d   = operands_i[1*WIDTH +: WIDTH];
          opc_d   = operands_i[2*WIDTH +: WIDTH];
          op_d    = op_i;
          tag_d   = tag_i;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          push    = !flush_i;
          state_d = S_IDLE;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else if (tmo_fire) begin
          push      = 1'b1;
          push_data = {{WIDTH{1'b0}}, 5'b10000, tag_q};
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (core_done_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, held operands and registered start pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      start_q <= start_d;
    end
  end

  // FIFO pointer/count update; flush overrides any push or pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = ptr_next(wptr_q);
      if (pop)  rptr_d = ptr_next(rptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push && !flush_i) mem_q[wptr_q] <= push_data;
    end
  end

endmodule
